mmio_fifo: RTL and testbench
============================

MMIO_FIFO -- requirements
Module: mmio_fifo

Interface
REQ-001 SHALL have parameter BASE, default 16'hFF00, 4-word-aligned base address of the register window.
REQ-002 SHALL have parameter DEPTH, default 16, entries per FIFO; power of two, 2..128.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports raddr  input  16, re  input  1, rdata  output  16: CPU read port.
REQ-006 SHALL have ports waddr  input  16, wdata  input  16, we  input  1: CPU write port.
REQ-007 SHALL have ports out_valid  output  1, out_data  output  16, out_ready  input  1: TX stream to external sink.
REQ-008 SHALL have ports in_valid  input  1, in_data  input  16, in_ready  output  1: RX stream from external source.

Function
REQ-009 SHALL decode an access as selected when addr[15:2] == BASE[15:2]; offset addr[1:0]: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-010 SHALL register rdata: value for the read presented with re in cycle N appears in cycle N+1; rdata is 0 in any cycle after an unselected or absent read, so rdata can be OR-muxed.
REQ-011 SHALL push wdata into TX FIFO on selected write to DATA when TX not full; when full, drop the data and set sticky TXOVF.
REQ-012 SHALL pop RX FIFO head into rdata on selected read of DATA when RX not empty; when empty, return 0, set sticky RXUND, leave FIFO unchanged.
REQ-013 SHALL return STATUS = {rx_count[7:0], 4'b0, RXUND, TXOVF, tx_full, rx_nonempty}; values sampled before any same-cycle update.
REQ-014 SHALL clear TXOVF/RXUND by writing 1 to the respective STATUS bit (W1C); other STATUS bits read-only; set and clear in the same cycle leaves bit set.
REQ-015 SHALL return 0 for reads of offset 3 and ignore writes to it.
REQ-016 SHALL drive out_valid = TX nonempty, out_data = TX head combinationally from FIFO state; pop on out_valid && out_ready.
REQ-017 SHALL drive in_ready = RX not full; push in_data on in_valid && in_ready.
REQ-018 SHALL perform simultaneous push and pop on one FIFO in one cycle with count unchanged; a full FIFO accepts no push even if popped that cycle.
REQ-019 SHALL allow re and we in the same cycle to any offsets; both take effect independently.
REQ-020 SHALL wrap FIFO pointers modulo DEPTH; count width log2(DEPTH)+1.

Reset
REQ-021 SHALL, while reset is high at a posedge, empty both FIFOs, clear TXOVF, RXUND, CTRL, rdata and irq; out_valid 0, in_ready 1 from the next cycle.
REQ-022 SHALL discard any access or stream transfer in the cycle reset is asserted.

Configuration
REQ-023 SHALL, with MMIO_FIFO_IRQ_EN defined, provide output irq (1 bit) and CTRL register bits [0] rx_ie, [1] tx_ie (read/write, others 0); irq registered = (rx_ie && rx_nonempty) || (tx_ie && TX empty), asserted one cycle after condition.
REQ-024 SHALL, without MMIO_FIFO_IRQ_EN, omit irq port; CTRL reads 0, writes ignored.

Structure
REQ-025 SHALL place register offsets, STATUS bit positions and CTRL bit positions in shared package mmio_pkg.
REQ-026 SHALL implement both FIFOs as two instances of sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head).

Verification
REQ-027 Write 16'h1234 to FF00, out_ready=1 -> out_valid next cycle with out_data 16'h1234, then out_valid 0.
REQ-028 out_ready=0, 17 writes to FF00 -> 17th dropped, STATUS bit1=1, bit2=1; write 16'h0004 to FF01 -> bit2=0.
REQ-029 in_data 16'hBEEF pushed, read FF01 then FF00 -> STATUS 16'h0101, then rdata 16'hBEEF, next STATUS 16'h0000.
REQ-030 Read FF00 with RX empty -> rdata 0, STATUS bit3=1; read FFF0 -> rdata 0, no state change.
REQ-031 RX full (16), same cycle read FF00 and in_valid=1 -> in_ready 0, pop occurs, count 15, next cycle in_ready 1.
REQ-032 With MMIO_FIFO_IRQ_EN, write 16'h0002 to FF02, TX empty -> irq 1 one cycle later; write FF00 -> irq 0 until drained; reset mid-burst -> irq 0, FIFOs empty.

Source files
------------

// File: rtl/mmio_pkg.sv
// Register map shared by the MMIO FIFO block and anything that talks to it.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: register offsets within the 4-word window, STATUS and CTRL bit positions.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_t;

  // STATUS layout: {rx_count[7:0], 4'b0, RXUND, TXOVF, tx_full, rx_nonempty}
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TXOVF       = 2;
  localparam int ST_RXUND       = 3;
  localparam int ST_RX_COUNT_LO = 8;

  // CTRL layout (only meaningful when the interrupt option is built in)
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH entries (power of two), head visible combinationally.
// Latency: pushed word is at head the cycle after push when FIFO was empty.
// Backpressure: push ignored while full (even if popped same cycle); pop ignored while empty.
// Ports: clk, reset (sync, active-high), push/din, pop, full, empty, count, head.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_fifo.sv
// CPU-mapped TX/RX FIFO pair: DATA/STATUS/CTRL window at BASE, streams to/from an external peer.
// Latency: rdata one cycle after re; TX word visible on out_* the cycle after the write.
// Backpressure: TX writes dropped when full (sticky TXOVF); RX reads of empty return 0 (sticky RXUND); in_ready = RX not full.
// Ports: clk, reset, CPU read (raddr/re/rdata), CPU write (waddr/wdata/we), TX stream out_*, RX stream in_*.
// Option: define MMIO_FIFO_IRQ_EN to add the irq output and the CTRL interrupt-enable bits.
module mmio_fifo
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raddr,
  input  logic        re,
  output logic [15:0] rdata,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready
`ifdef MMIO_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [15:0]   tx_head, rx_head;

  logic          rd_sel, wr_sel;
  reg_off_t      rd_off, wr_off;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          txovf, rxund;
  logic          txovf_set, rxund_set, txovf_clr, rxund_clr;
  logic [15:0]   status;
  logic [15:0]   rdata_nxt;

  assign rd_sel = re && (raddr[15:2] == BASE[15:2]);
  assign wr_sel = we && (waddr[15:2] == BASE[15:2]);
  assign rd_off = reg_off_t'(raddr[1:0]);
  assign wr_off = reg_off_t'(waddr[1:0]);

  assign tx_push   = wr_sel && (wr_off == REG_DATA) && !tx_full;
  assign txovf_set = wr_sel && (wr_off == REG_DATA) &&  tx_full;
  assign rx_pop    = rd_sel && (rd_off == REG_DATA) && !rx_empty;
  assign rxund_set = rd_sel && (rd_off == REG_DATA) &&  rx_empty;
  assign txovf_clr = wr_sel && (wr_off == REG_STATUS) && wdata[ST_TXOVF];
  assign rxund_clr = wr_sel && (wr_off == REG_STATUS) && wdata[ST_RXUND];

  assign out_valid = !tx_empty;
  assign out_data  = tx_head;
  assign tx_pop    = out_valid && out_ready;
  assign in_ready  = !rx_full;
  assign rx_push   = in_valid && in_ready;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (wdata),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (in_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

`ifdef MMIO_FIFO_IRQ_EN
  logic [1:0] ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_sel && (wr_off == REG_CTRL)) ctrl <= wdata[1:0];
      irq <= (ctrl[CTRL_RX_IE] && !rx_empty) || (ctrl[CTRL_TX_IE] && tx_empty);
    end
  end
`endif

  // STATUS reflects state before this cycle's updates; tx_count is not exposed.
  always_comb begin
    status                  = '0;
    status[15:8]            = 8'(rx_count);
    status[ST_RXUND]        = rxund;
    status[ST_TXOVF]        = txovf;
    status[ST_TX_FULL]      = tx_full;
    status[ST_RX_NONEMPTY]  = !rx_empty;
    status[7:4]             = 4'(tx_count & '0);
  end

  // Zero whenever no selected read happened, so rdata can be OR-combined upstream.
  always_comb begin
    rdata_nxt = '0;
    if (rd_sel) begin
      case (rd_off)
        REG_DATA:   rdata_nxt = rx_empty ? 16'h0000 : rx_head;
        REG_STATUS: rdata_nxt = status;
`ifdef MMIO_FIFO_IRQ_EN
        REG_CTRL:   rdata_nxt = {14'd0, ctrl};
`endif
        default:    rdata_nxt = '0;
      endcase
    end
  end

  // A same-cycle set wins over a W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      txovf <= 1'b0;
      rxund <= 1'b0;
    end else begin
      rdata <= rdata_nxt;
      txovf <= txovf_set || (txovf && !txovf_clr);
      rxund <= rxund_set || (rxund && !rxund_clr);
    end
  end

endmodule

// File: tb/tb_mmio_fifo.sv
// Directed self-checking bench for mmio_fifo (default DEPTH=16, BASE=FF00).
// Inputs driven on negedge, outputs sampled on negedge.
// Irq checks are compiled in when MMIO_FIFO_IRQ_EN is defined.
module tb_mmio_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] raddr, waddr, wdata, in_data;
  logic        re, we, out_ready, in_valid;
  logic [15:0] rdata, out_data;
  logic        out_valid, in_ready;
`ifdef MMIO_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .raddr     (raddr),
    .re        (re),
    .rdata     (rdata),
    .waddr     (waddr),
    .wdata     (wdata),
    .we        (we),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready)
`ifdef MMIO_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    re = 1'b1; raddr = a;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  logic [15:0] v;

  initial begin
    reset = 1'b1; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rdata", rdata, 0);
    cpu_read(16'hFF01, v);
    chk("rst_status", v, 16'h0000);

    // Single TX word passes straight through
    out_ready = 1'b1;
    cpu_write(16'hFF00, 16'h1234);
    chk("tx1_valid", out_valid, 1);
    chk("tx1_data", out_data, 16'h1234);
    @(negedge clk);
    chk("tx1_drained", out_valid, 0);

    // TX overflow: 17th word dropped, TXOVF sticky, W1C clear
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) cpu_write(16'hFF00, 16'h0A00 + 16'(i));
    cpu_write(16'hFF00, 16'hDEAD);
    cpu_read(16'hFF01, v);
    chk("txovf_status", v, 16'h0006);
    cpu_write(16'hFF01, 16'h0004);
    cpu_read(16'hFF01, v);
    chk("txovf_cleared", v, 16'h0002);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 16'h0A00 + 16'(i));
      @(negedge clk);
    end
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // RX single word: STATUS, DATA, STATUS
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    cpu_read(16'hFF01, v);
    chk("rx1_status", v, 16'h0101);
    cpu_read(16'hFF00, v);
    chk("rx1_data", v, 16'hBEEF);
    cpu_read(16'hFF01, v);
    chk("rx1_status_after", v, 16'h0000);

    // RX underflow, unselected and reserved reads
    cpu_read(16'hFF00, v);
    chk("rxund_data", v, 16'h0000);
    cpu_read(16'hFF01, v);
    chk("rxund_status", v, 16'h0008);
    cpu_read(16'hFFF0, v);
    chk("unsel_rdata", v, 16'h0000);
    cpu_read(16'hFF03, v);
    chk("rsvd_rdata", v, 16'h0000);
    cpu_read(16'hFF01, v);
    chk("unsel_nochange", v, 16'h0008);

    // Underflow set and W1C clear in the same cycle: set wins
    @(negedge clk);
    re = 1'b1; raddr = 16'hFF00; we = 1'b1; waddr = 16'hFF01; wdata = 16'h0008;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    cpu_read(16'hFF01, v);
    chk("setclr_wins", v, 16'h0008);
    cpu_write(16'hFF01, 16'h0008);
    cpu_read(16'hFF01, v);
    chk("rxund_cleared", v, 16'h0000);

    // Fill RX, then pop and offer a push in the same cycle
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    chk("rx_full_ready", in_ready, 0);
    in_data = 16'hAAAA;
    re = 1'b1; raddr = 16'hFF00;
    @(negedge clk);
    re = 1'b0; in_valid = 1'b0;
    chk("full_pop_data", rdata, 16'h0100);
    chk("full_pop_ready", in_ready, 1);
    cpu_read(16'hFF01, v);
    chk("full_pop_count", v, 16'h0F01);
    for (int i = 1; i < 16; i++) begin
      cpu_read(16'hFF00, v);
      chk("rx_order", v, 16'h0100 + 16'(i));
    end
    cpu_read(16'hFF01, v);
    chk("rx_drained", v, 16'h0000);

`ifdef MMIO_FIFO_IRQ_EN
    cpu_write(16'hFF02, 16'h0002);
    chk("irq_not_yet", irq, 0);
    @(negedge clk);
    chk("irq_tx_empty", irq, 1);
    cpu_read(16'hFF02, v);
    chk("ctrl_rd", v, 16'h0002);
    cpu_write(16'hFF00, 16'h5555);
    @(negedge clk);
    chk("irq_tx_busy", irq, 0);
    cpu_write(16'hFF00, 16'h6666);
    chk("irq_still_busy", irq, 0);
`else
    cpu_write(16'hFF02, 16'h0003);
    cpu_read(16'hFF02, v);
    chk("ctrl_rd_zero", v, 16'h0000);
    cpu_write(16'hFF00, 16'h5555);
    cpu_write(16'hFF00, 16'h6666);
`endif

    // Reset mid-burst, with a write and RX push offered in the reset cycle
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    reset = 1'b1; we = 1'b1; waddr = 16'hFF00; wdata = 16'h7777;
    in_valid = 1'b1; in_data = 16'h4321;
    @(negedge clk);
    reset = 1'b0; we = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
`ifdef MMIO_FIFO_IRQ_EN
    chk("mid_rst_irq", irq, 0);
`endif
    cpu_read(16'hFF01, v);
    chk("mid_rst_status", v, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
